// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: sequences start/data/parity/stop phases for an
// external serializer, computes parity and aborts frames whose serializer stalls.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 10
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_done,
  input  logic                  ser_data,
  output logic                  ser_load,
  output logic                  ser_en,
  output logic [1:0]            mux_sel,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  frame_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t        state, nxt;
  logic [CW-1:0] tcnt;
  logic          par_bit, par_en_q;
  logic          accept, tout;

  assign accept   = ((state == S_IDLE) || (state == S_STOP)) && DATA_VALID;
  assign ser_load = accept;
  // tcnt holds completed DATA cycles, so this fires in the TIMEOUT-th one
  assign tout     = (state == S_DATA) && !ser_done && (tcnt == CW'(TIMEOUT - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      par_bit  <= 1'b0;
      par_en_q <= 1'b0;
      tcnt     <= '0;
    end else begin
      if (accept) begin
        par_bit  <= (^P_DATA) ^ PAR_TYP;
        par_en_q <= PAR_EN;
      end
      if (state == S_DATA) tcnt <= tcnt + CW'(1);
      else                 tcnt <= '0;
    end
  end

  always_comb begin
    nxt       = state;
    ser_en    = 1'b0;
    mux_sel   = 2'b01;
    busy      = 1'b0;
    frame_err = 1'b0;
    case (state)
      S_IDLE: if (accept) nxt = S_START;
      S_START: begin
        mux_sel = 2'b00;
        busy    = 1'b1;
        ser_en  = 1'b1;
        nxt     = S_DATA;
      end
      S_DATA: begin
        mux_sel = 2'b10;
        busy    = 1'b1;
        ser_en  = !ser_done;
        if (ser_done) begin
          nxt = par_en_q ? S_PARITY : S_STOP;
        end else if (tout) begin
          frame_err = 1'b1;
          mux_sel   = 2'b01;
          nxt       = S_IDLE;
        end
      end
      S_PARITY: begin
        mux_sel = 2'b11;
        busy    = 1'b1;
        nxt     = S_STOP;
      end
      S_STOP: begin
        busy = 1'b1;
        nxt  = accept ? S_START : S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    case (mux_sel)
      2'b00:   TX_OUT = 1'b0;
      2'b10:   TX_OUT = ser_data;
      2'b11:   TX_OUT = par_bit;
      default: TX_OUT = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: stimulus queues expected frames, a monitor
// rebuilds each transmitted line sequence and compares it against a frame model.
module tb_uart_tx_ctrl;

  logic       CLK = 1'b0, RST = 1'b1;
  logic [7:0] P_DATA = 8'h00;
  logic       DATA_VALID = 1'b0, PAR_EN = 1'b0, PAR_TYP = 1'b0;
  logic       ser_done, ser_data;
  logic       ser_load, ser_en, TX_OUT, busy, frame_err;
  logic [1:0] mux_sel;

  int   nchk = 0, nerr = 0;
  logic force_done = 1'b0, tie_zero = 1'b0;

  typedef struct {
    logic [7:0] d;
    bit         pen;
    bit         pbit;
    bit         tout;
  } frame_t;
  frame_t exp_q[$];

  always #5 CLK = ~CLK;

  uart_tx_ctrl #(.DATA_WIDTH(8), .TIMEOUT(10)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .ser_done(ser_done), .ser_data(ser_data),
    .ser_load(ser_load), .ser_en(ser_en), .mux_sel(mux_sel), .TX_OUT(TX_OUT),
    .busy(busy), .frame_err(frame_err)
  );

  // Serializer stand-in: cnt=1 in START, DATA cycle k has cnt=k+1; done on DATA cycle 9.
  int         cnt;
  logic [7:0] sbyte;
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt   <= 0;
      sbyte <= 8'h00;
    end else if (ser_load) begin
      cnt   <= 1;
      sbyte <= P_DATA;
    end else if (cnt != 0 && cnt < 15) begin
      cnt <= cnt + 1;
    end
  end
  assign ser_done = force_done | ((cnt == 10) & ~tie_zero);
  assign ser_data = (cnt >= 2 && cnt <= 9) ? sbyte[cnt-2] : sbyte[7];

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  logic [15:0] line;
  int          llen = 0, loads = 0;
  bit          in_frame = 0;

  task automatic end_frame();
    frame_t      e;
    logic [15:0] ev;
    int          n;
    if (exp_q.size() == 0) begin
      nchk++; nerr++;
      $display("FAIL unexpected_frame: got line %0h len %0d, none expected", line, llen);
      return;
    end
    e = exp_q.pop_front();
    ev = '0; n = 0;
    ev[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin ev[n] = e.d[i]; n++; end
    ev[n] = e.d[7]; n++;
    if (e.tout) begin
      ev[n] = 1'b1; n++;
    end else begin
      if (e.pen) begin ev[n] = e.pbit; n++; end
      ev[n] = 1'b1; n++;
    end
    check("frame_len", llen, n);
    check("frame_line", line, ev);
    check("frame_err_flag", frame_err, e.tout);
  endtask

  initial forever begin
    @(negedge CLK);
    if (RST) begin
      in_frame = 0;
      loads    = 0;
      exp_q.delete();
    end else begin
      if (busy && mux_sel == 2'b00) begin
        check("load_before_start", loads, 1);
        loads = 0; in_frame = 1; llen = 0; line = '0;
      end
      if (ser_load) loads++;
      if (in_frame) begin
        if (llen < 16) line[llen] = TX_OUT;
        llen++;
        if (frame_err || (busy && mux_sel == 2'b01)) begin
          end_frame();
          in_frame = 0;
        end
      end else if (frame_err) begin
        check("stray_frame_err", frame_err, 0);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 of the START cycle.
  task automatic issue(input logic [7:0] d, input bit pen, input bit typ,
                       input bit tout, input bit hold, input bit b2b);
    frame_t e;
    int     n = 0;
    e.d = d; e.pen = pen; e.tout = tout;
    e.pbit = (($countones(d) % 2) == 1) ^ typ;
    exp_q.push_back(e);
    P_DATA = d; PAR_EN = pen; PAR_TYP = typ; tie_zero = tout; DATA_VALID = 1'b1;
    #1;
    while (!ser_load && n < 100) begin tick(); n++; end
    check("accept_seen", ser_load, 1);
    if (b2b) check("b2b_accept_in_stop", {busy, mux_sel}, 3'b101);
    tick();
    if (!hold) DATA_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin tick(); n++; end
    check("idle_reached", busy, 0);
  endtask

  initial begin
    #12;
    check("rst_busy", busy, 0);
    check("rst_ser_en", ser_en, 0);
    check("rst_ser_load", ser_load, 0);
    check("rst_mux_sel", mux_sel, 2'b01);
    check("rst_tx_out", TX_OUT, 1);
    check("rst_frame_err", frame_err, 0);
    tick();
    RST = 1'b0;
    tick();

    // even parity, odd parity, no parity
    issue(8'hA5, 1, 0, 0, 0, 0); wait_idle();
    issue(8'h01, 1, 1, 0, 0, 0); wait_idle();
    issue(8'h01, 0, 1, 0, 0, 0); wait_idle();

    // back-to-back with config changed mid-frame
    issue(8'h55, 1, 0, 0, 1, 0);
    issue(8'h0F, 1, 1, 0, 0, 1);
    wait_idle();

    // stalled serializer
    begin
      int n = 0;
      issue(8'hC3, 1, 0, 1, 0, 0);
      while (!frame_err && n < 50) begin tick(); n++; end
      check("timeout_seen", frame_err, 1);
      check("timeout_cycle", n, 10);
      tick();
      check("timeout_err_pulse", frame_err, 0);
      check("timeout_busy", busy, 0);
      check("timeout_line", TX_OUT, 1);
      tie_zero = 1'b0;
      issue(8'h3A, 1, 1, 0, 0, 0); wait_idle();
    end

    // request during PARITY is ignored
    begin
      int n = 0;
      issue(8'h3C, 1, 0, 0, 0, 0);
      while (mux_sel != 2'b11 && n < 50) begin tick(); n++; end
      DATA_VALID = 1'b1; P_DATA = 8'hFF;
      #1;
      check("parity_req_ignored", ser_load, 0);
      tick();
      DATA_VALID = 1'b0;
      wait_idle();
    end

    // async reset in DATA cycle 4, then stale ser_done in IDLE
    issue(8'h96, 1, 0, 0, 0, 0);
    repeat (4) tick();
    check("pre_rst_in_data", mux_sel, 2'b10);
    #2 RST = 1'b1;
    #1;
    check("async_rst_tx_out", TX_OUT, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_ser_en", ser_en, 0);
    check("async_rst_frame_err", frame_err, 0);
    tick(); tick();
    RST = 1'b0; force_done = 1'b1;
    repeat (3) begin
      tick();
      check("stale_done_busy", busy, 0);
      check("stale_done_mux", mux_sel, 2'b01);
    end
    force_done = 1'b0;

    // randomized frames
    for (int it = 0; it < 30; it++) begin
      logic [7:0] d1, d2;
      int mode;
      d1 = 8'($urandom); d2 = 8'($urandom);
      mode = $urandom_range(0, 5);
      if (mode == 0) begin
        issue(d1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 0, 0);
      end else if (mode <= 2) begin
        issue(d1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 1, 0);
        issue(d2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, 1);
      end else begin
        issue(d1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, 0);
      end
      wait_idle();
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", nerr);
    $fatal(1, "watchdog");
  end

endmodule
